aes_stream_ctrl: RTL
====================

// Module: aes_stream_ctrl
// PURPOSE
//  Word-serial streaming front end for a 128-bit AES cipher core; successor to fixed 4x32-bit word ports.
//  Gathers NWORDS = 128/BUS_W input beats into a block, then launches the core via start/done handshake.
//  Optionally XORs the block with a CBC chain value, then returns the result as BUS_W beats.
//  Double-buffered: the next block fills while the current one is in the core or draining.
// PARAMETERS
//  BUS_W   32  stream word width; legal 8,16,32,64,128 (NWORDS = 128/BUS_W)
//  CNT_W   16  width of completed-block counter
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      asynchronous, active-low; clears all state
//  cbc_en     in   1      1 = CBC chaining, 0 = ECB; sampled in S_START
//  iv_load    in   1      load iv_in into chain register (honoured only in S_FILL)
//  iv_in      in   128    initialisation vector
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_data    in   BUS_W  input beat; first beat = block bits [BUS_W-1:0]
//  core_pt    out  128    block to core, registered, stable from S_START until core_done
//  core_start out  1      one-cycle pulse launching core
//  core_ct    in   128    core result, valid with core_done
//  core_done  in   1      core completion pulse
//  out_valid  out  1      output beat valid
//  out_ready  in   1      output beat consumed when out_valid & out_ready
//  out_data   out  BUS_W  output beat; first beat = result bits [BUS_W-1:0]
//  busy       out  1      1 whenever state != S_FILL
//  block_cnt  out  CNT_W  blocks completed (core_done captures), wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: all outputs 0, in_cnt=0, out_idx=0, chain=0, state=S_FILL; in_ready goes 1 on first edge after release.
//  Input buffer: in_cnt counts 0..NWORDS; in_ready = (in_cnt != NWORDS) in every state.
//   Accepted beat k is written to bits [k*BUS_W +: BUS_W]; in_cnt cleared in the S_START cycle (buffer freed).
//  FSM:
//   S_FILL : if in_cnt==NWORDS -> S_START.
//   S_START: core_pt <= buf ^ (cbc_en ? chain : 0); core_start=1 for exactly 1 cycle -> S_WAIT.
//   S_WAIT : on core_done: res <= core_ct; if cbc_en latched, chain <= core_ct; block_cnt++ -> S_DRAIN.
//   S_DRAIN: out_valid=1, out_data=res[out_idx*BUS_W +: BUS_W]; out_idx++ per handshake.
//            On last beat accepted: out_idx=0; -> S_START if in_cnt==NWORDS, else S_FILL.
//  Latency: last input beat -> core_start = 2 cycles; core_done -> out_valid = 1 cycle.
//  out_data/out_valid held stable while out_ready=0; no beat dropped or duplicated.
//  core_done outside S_WAIT ignored; core_start never reasserted before core_done.
//  iv_load in S_FILL on the same edge as the final input beat: new IV used for that block.
//  iv_load while busy: ignored (chain unchanged).
//  cbc_en change mid-block: only the value in S_START applies to that block.
//  BUS_W=128: NWORDS=1, single beat in and out, index logic degenerates to constant 0.
//  Reset asserted mid-operation: immediate clear; in-flight block and buffered beats discarded.
// TESTING (stub core: core_ct = ~core_pt, core_done 3 cycles after core_start)
//  ECB, BUS_W=32: beats 6f6e6f43,6f4e2072,206e616c,54494d47
//    -> core_pt=128'h54494d47206e616c6f4e20726f6e6f43; out 909190bc,90b1df8d,df919e93,abb6b2b8.
//  CBC: iv_load iv=128'hA5..A5, two zero blocks
//    -> core_pt #1 = A5..A5, #2 = 5A..5A; out = 5A..5A then A5..A5; block_cnt=2.
//  Backpressure: out_ready=0 for 5 cycles in S_DRAIN while 4 more beats arrive
//    -> out_data stable, in_ready=0 after 4th beat, next core_start follows last drained beat +1 cycle.
//  Reset mid-S_WAIT: reset=0 -> all outputs 0 asynchronously; later core_done ignored; block_cnt=0.
//  Width sweep: BUS_W=8 (16 beats) and BUS_W=128 (1 beat) with ECB vector above -> same core_pt/results.
//  Wrap: CNT_W=2, 5 blocks -> block_cnt=1; iv_load while busy -> chain unchanged (checked by next CBC block).

Source files
------------

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: word-serial double-buffered stream front end for a 128-bit AES core with optional CBC chaining
module aes_stream_ctrl #(
  parameter int BUS_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cbc_en,
  input  logic             iv_load,
  input  logic [127:0]     iv_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic [127:0]     core_pt,
  output logic             core_start,
  input  logic [127:0]     core_ct,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] block_cnt
);
  localparam int NWORDS = 128 / BUS_W;
  localparam int IDX_W = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam int CW = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] FULL = CW'(NWORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);
  typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DRAIN} state_t;
  state_t state, state_n;
  logic [NWORDS-1:0][BUS_W-1:0] blk_q, res_q;
  logic [CW-1:0] in_cnt, in_cnt_n;
  logic [IDX_W-1:0] out_idx;
  logic [127:0] chain;
  logic cbc_q, full, in_fire, out_fire, out_last;
  assign full = in_cnt == FULL;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_last = out_idx == LAST;
  assign core_start = state == S_START;
  assign out_valid = state == S_DRAIN;
  assign busy = state != S_FILL;
  assign out_data = res_q[out_idx];
  assign in_cnt_n = state == S_START ? '0 : in_cnt + CW'(in_fire);
  always_comb begin
    state_n = state == S_FILL  ? (full ? S_START : S_FILL) :
              state == S_START ? S_WAIT :
              state == S_WAIT  ? (core_done ? S_DRAIN : S_WAIT) :
              (out_fire && out_last) ? (full ? S_START : S_FILL) : S_DRAIN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FILL;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt <= '0;
      in_ready <= 1'b0;
      blk_q <= '0;
      res_q <= '0;
      core_pt <= '0;
      chain <= '0;
      cbc_q <= 1'b0;
      out_idx <= '0;
      block_cnt <= '0;
    end else begin
      in_cnt <= in_cnt_n;
      in_ready <= in_cnt_n != FULL;
      if (in_fire) blk_q[in_cnt[IDX_W-1:0]] <= in_data;
      if (state_n == S_START) begin
        core_pt <= blk_q ^ (cbc_en ? chain : '0);
        cbc_q <= cbc_en;
      end
      if (iv_load && state == S_FILL) chain <= iv_in;
      if (state == S_WAIT && core_done) begin
        res_q <= core_ct;
        block_cnt <= block_cnt + CNT_W'(1);
        if (cbc_q) chain <= core_ct;
      end
      if (out_fire) out_idx <= out_last ? '0 : out_idx + IDX_W'(1);
    end
  end
endmodule
